// File: rtl/axi4_lite_supporter.sv
// axi4_lite_supporter: AXI4-Lite subordinate register file.
// Sixteen 32-bit registers addressed by addr[5:2]. Indices 0-14 are
// read/write with byte strobes; index 15 returns the user status word and
// rejects writes with SLVERR. Write and read channels use independent FSMs.
// Ports:
//   S_AXI_*     AXI4-Lite subordinate interface (clock, sync active-high reset,
//               AW/W/B write channels, AR/R read channels)
//   status      value returned for register 15
//   ctrl0       current value of register 0
//   regWrPulse  one-cycle pulse per committed write to registers 0-14
//   regWrIdx    index of that write, valid while regWrPulse=1
module axi4_lite_supporter #(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   status,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl0,
  output logic                            regWrPulse,
  output logic [3:0]                      regWrIdx
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int SW     = C_S_AXI_DATA_WIDTH / 8;
  localparam int NUM_RW = 15;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  w_state_e        w_state_q, w_state_d;
  r_state_e        r_state_q, r_state_d;
  logic [DW-1:0]   regs_q [NUM_RW];
  logic [DW-1:0]   regs_d [NUM_RW];

  logic            awready_q, awready_d, wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [3:0]      aw_idx_q, aw_idx_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            pulse_q, pulse_d;
  logic [3:0]      wr_idx_q, wr_idx_d;
  logic            arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            aw_hs_s, w_hs_s, have_aw_s, have_w_s, wr_commit_s, ar_hs_s;
  logic [3:0]      wr_idx_s, ar_idx_s;
  logic [DW-1:0]   wr_data_s, rd_sel_s;
  logic [SW-1:0]   wr_strb_s;
  logic            unused_addr_lsb_s;

  // Byte-offset bits do not select anything.
  assign unused_addr_lsb_s = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // A channel counts as present if it is handshaking now or was latched earlier;
  // the commit uses the live bus value when the handshake is this cycle.
  assign aw_hs_s   = awready_q & S_AXI_AWVALID;
  assign w_hs_s    = wready_q & S_AXI_WVALID;
  assign have_aw_s = aw_held_q | aw_hs_s;
  assign have_w_s  = w_held_q | w_hs_s;
  assign wr_idx_s  = aw_hs_s ? S_AXI_AWADDR[5:2] : aw_idx_q;
  assign wr_data_s = w_hs_s ? S_AXI_WDATA : wdata_q;
  assign wr_strb_s = w_hs_s ? S_AXI_WSTRB : wstrb_q;
  assign ar_hs_s   = arready_q & S_AXI_ARVALID;
  assign ar_idx_s  = S_AXI_ARADDR[5:2];

  // Write FSM next-state and output logic.
  always_comb begin
    w_state_d   = w_state_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    aw_held_d   = aw_held_q;
    aw_idx_d    = aw_idx_q;
    w_held_d    = w_held_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    pulse_d     = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_commit_s = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (have_aw_s && have_w_s) begin
          wr_commit_s = 1'b1;
          w_state_d   = W_RESP;
          awready_d   = 1'b0;
          wready_d    = 1'b0;
          bvalid_d    = 1'b1;
          aw_held_d   = 1'b0;
          w_held_d    = 1'b0;
          if (wr_idx_s == 4'd15) begin
            bresp_d = 2'b10;
          end else begin
            bresp_d  = 2'b00;
            pulse_d  = 1'b1;
            wr_idx_d = wr_idx_s;
          end
        end else begin
          // Only one channel so far: drop its ready, keep the other open.
          aw_held_d = have_aw_s;
          w_held_d  = have_w_s;
          awready_d = ~have_aw_s;
          wready_d  = ~have_w_s;
          if (aw_hs_s) begin
            aw_idx_d = S_AXI_AWADDR[5:2];
          end else begin
            aw_idx_d = aw_idx_q;
          end
          if (w_hs_s) begin
            wdata_d = S_AXI_WDATA;
            wstrb_d = S_AXI_WSTRB;
          end else begin
            wdata_d = wdata_q;
            wstrb_d = wstrb_q;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = 2'b00;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        bresp_d   = 2'b00;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
      end
    endcase
  end

  // Byte-masked register update on commit; index 15 never matches.
  always_comb begin
    for (int i = 0; i < NUM_RW; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_commit_s && (wr_idx_s == 4'(i))) begin
        for (int n = 0; n < SW; n++) begin
          regs_d[i][8*n +: 8] = wr_strb_s[n] ? wr_data_s[8*n +: 8] : regs_q[i][8*n +: 8];
        end
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Read source mux: status word unless a read/write register matches.
  always_comb begin
    rd_sel_s = status;
    for (int i = 0; i < NUM_RW; i++) begin
      if (ar_idx_s == 4'(i)) begin
        rd_sel_s = regs_q[i];
      end else begin
        rd_sel_s = rd_sel_s;
      end
    end
  end

  // Read FSM next-state and output logic.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_d = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_sel_s;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      for (int i = 0; i < NUM_RW; i++) begin
        regs_q[i] <= '0;
      end
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      aw_held_q <= 1'b0;
      aw_idx_q  <= 4'd0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      pulse_q   <= 1'b0;
      wr_idx_q  <= 4'd0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      for (int i = 0; i < NUM_RW; i++) begin
        regs_q[i] <= regs_d[i];
      end
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      pulse_q   <= pulse_d;
      wr_idx_q  <= wr_idx_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign ctrl0         = regs_q[0];
  assign regWrPulse    = pulse_q;
  assign regWrIdx      = wr_idx_q;

endmodule

// File: tb/tb_axi4_lite_supporter.sv
// tb_axi4_lite_supporter: directed self-checking bench for axi4_lite_supporter.
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_axi4_lite_supporter;

  logic        clk;
  logic        areset;
  logic [5:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [5:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] status;
  logic [31:0] ctrl0;
  logic        wr_pulse;
  logic [3:0]  wr_idx;

  int checks_cnt;
  int errors_cnt;

  axi4_lite_supporter dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (areset),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .status       (status),
    .ctrl0        (ctrl0),
    .regWrPulse   (wr_pulse),
    .regWrIdx     (wr_idx)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AW and W together with BREADY high; checks response and pulse.
  task automatic do_write(input string tag, input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] exp_resp,
                          input logic exp_pulse, input logic [3:0] exp_idx);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_val({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    check_val({tag, "_bresp"},  32'(bresp), 32'(exp_resp));
    check_val({tag, "_pulse"},  32'(wr_pulse), 32'(exp_pulse));
    if (exp_pulse) check_val({tag, "_idx"}, 32'(wr_idx), 32'(exp_idx));
    tick();
    check_val({tag, "_bdone"},  32'(bvalid), 32'd0);
  endtask

  // AR with RREADY high; RVALID must rise one cycle after the AR handshake.
  task automatic do_read(input string tag, input logic [5:0] a, input logic [31:0] exp);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    check_val({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check_val({tag, "_rdata"},  rdata, exp);
    check_val({tag, "_rresp"},  32'(rresp), 32'd0);
    tick();
    check_val({tag, "_rdone"},  32'(rvalid), 32'd0);
  endtask

  initial begin
    checks_cnt = 0; errors_cnt = 0;
    areset = 1'b1; awaddr = 6'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0;
    wvalid = 1'b0; bready = 1'b0; araddr = 6'd0; arvalid = 1'b0; rready = 1'b0;
    status = 32'd0;

    // Reset state.
    tick(); tick();
    check_val("rst_awready", 32'(awready), 32'd0);
    check_val("rst_wready",  32'(wready), 32'd0);
    check_val("rst_arready", 32'(arready), 32'd0);
    check_val("rst_bvalid",  32'(bvalid), 32'd0);
    check_val("rst_rvalid",  32'(rvalid), 32'd0);
    check_val("rst_ctrl0",   ctrl0, 32'd0);
    areset = 1'b0;
    tick();
    check_val("post_awready", 32'(awready), 32'd1);
    check_val("post_wready",  32'(wready), 32'd1);
    check_val("post_arready", 32'(arready), 32'd1);

    // AW+W same cycle to reg1.
    do_write("w1", 6'h04, 32'hDEADBEEF, 4'hF, 2'b00, 1'b1, 4'd1);
    check_val("w1_awready_back", 32'(awready), 32'd1);
    check_val("w1_wready_back",  32'(wready), 32'd1);
    do_read("r1", 6'h04, 32'hDEADBEEF);

    // W three cycles ahead of AW to reg0.
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    tick();
    wvalid = 1'b0;
    check_val("wfirst_wready",  32'(wready), 32'd0);
    check_val("wfirst_awready", 32'(awready), 32'd1);
    check_val("wfirst_bvalid",  32'(bvalid), 32'd0);
    tick(); tick();
    check_val("wfirst_wready_hold", 32'(wready), 32'd0);
    awaddr = 6'h00; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check_val("wfirst_bvalid2", 32'(bvalid), 32'd1);
    check_val("wfirst_pulse",   32'(wr_pulse), 32'd1);
    check_val("wfirst_idx",     32'(wr_idx), 32'd0);
    check_val("wfirst_ctrl0",   ctrl0, 32'h12345678);
    tick();
    check_val("wfirst_bdone",   32'(bvalid), 32'd0);

    // Byte strobes on reg2.
    do_write("w2a", 6'h08, 32'hAABBCCDD, 4'hF, 2'b00, 1'b1, 4'd2);
    do_write("w2b", 6'h08, 32'h11223344, 4'h5, 2'b00, 1'b1, 4'd2);
    do_read("r2", 6'h08, 32'hAA22CC44);

    // Zero strobe: pulse, no data change.
    do_write("w2z", 6'h08, 32'hFFFFFFFF, 4'h0, 2'b00, 1'b1, 4'd2);
    do_read("r2z", 6'h08, 32'hAA22CC44);

    // Status register: write rejected, read returns status.
    status = 32'hCAFEF00D;
    do_write("w15", 6'h3C, 32'h01020304, 4'hF, 2'b10, 1'b0, 4'd0);
    do_read("r15", 6'h3C, 32'hCAFEF00D);

    // Backpressure with concurrent write and read of reg2.
    awaddr = 6'h08; awvalid = 1'b1; wdata = 32'h55667788; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b0; araddr = 6'h08; arvalid = 1'b1; rready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check_val("bp_bvalid", 32'(bvalid), 32'd1);
    check_val("bp_rvalid", 32'(rvalid), 32'd1);
    check_val("bp_rdata",  rdata, 32'hAA22CC44);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("bp_bvalid_hold", 32'(bvalid), 32'd1);
      check_val("bp_bresp_hold",  32'(bresp), 32'd0);
      check_val("bp_rvalid_hold", 32'(rvalid), 32'd1);
      check_val("bp_rdata_hold",  rdata, 32'hAA22CC44);
      check_val("bp_readies", 32'({awready, wready, arready}), 32'd0);
      check_val("bp_pulse_off", 32'(wr_pulse), 32'd0);
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    check_val("bp_bdone", 32'(bvalid), 32'd0);
    check_val("bp_rdone", 32'(rvalid), 32'd0);
    do_read("bp_new", 6'h08, 32'h55667788);

    // Reset while in W_RESP and R_DATA.
    awaddr = 6'h14; awvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b0; araddr = 6'h04; arvalid = 1'b1; rready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check_val("mid_bvalid", 32'(bvalid), 32'd1);
    check_val("mid_rvalid", 32'(rvalid), 32'd1);
    areset = 1'b1;
    tick();
    check_val("mr_bvalid",  32'(bvalid), 32'd0);
    check_val("mr_rvalid",  32'(rvalid), 32'd0);
    check_val("mr_ctrl0",   ctrl0, 32'd0);
    check_val("mr_readies", 32'({awready, wready, arready}), 32'd0);
    areset = 1'b0; bready = 1'b1; rready = 1'b1;
    tick();
    check_val("mr_awready", 32'(awready), 32'd1);
    check_val("mr_arready", 32'(arready), 32'd1);
    do_read("mr_r1", 6'h04, 32'd0);
    do_read("mr_r5", 6'h14, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
